store_unit: RTL

Store-path counterpart of the MEM-stage load extractor. Accepts one store per handshake (type, byte address, register data) and drives the data-memory write port with word-aligned address, lane-shifted write data and byte strobes. Misaligned halfword/word stores are split into two word beats. Sits between the MEM stage and the data-memory bus; the pipeline stalls on `st_ready` low.

---
 rtl/store_unit_pkg.sv | 18 +
 rtl/store_align.sv | 41 ++++
 rtl/store_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared load/store type codes and helpers for the MEM stage
package store_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic is_store_type(input logic [2:0] t);
        return (t == SB) || (t == SH) || (t == SW);
    endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - maps a store (type, byte offset, data) onto two words of lanes
module store_align
    import store_unit_pkg::*;
(
    input  logic [2:0]  store_type,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [63:0] data64,
    output logic [7:0]  strb8,
    output logic        need_beat1
);

    logic [31:0] base_data;
    logic [3:0]  base_strb;

    always_comb begin
        base_data = 32'd0;
        base_strb = 4'b0000;
        case (store_type)
            SB: begin
                base_data = {24'd0, data[7:0]};
                base_strb = 4'b0001;
            end
            SH: begin
                base_data = {16'd0, data[15:0]};
                base_strb = 4'b0011;
            end
            SW: begin
                base_data = data;
                base_strb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Upper word catches lanes that spill past the end of the addressed word.
    assign data64     = {32'd0, base_data} << {off, 3'b000};
    assign strb8      = {4'b0000, base_strb} << off;
    assign need_beat1 = |strb8[7:4];

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store path: lane-aligns stores and issues one or two word write beats
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  store_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] data64;
    logic [7:0]  strb8;
    logic        need_beat1;

    logic        b1_pending;
    logic [31:0] b1_addr;
    logic [31:0] b1_wdata;
    logic [3:0]  b1_wstrb;

    store_align u_align (
        .store_type (store_type),
        .off        (st_addr[1:0]),
        .data       (st_data),
        .data64     (data64),
        .strb8      (strb8),
        .need_beat1 (need_beat1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            st_ready    <= 1'b1;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'b0000;
            st_done     <= 1'b0;
            st_misalign <= 1'b0;
            b1_pending  <= 1'b0;
            b1_addr     <= 32'd0;
            b1_wdata    <= 32'd0;
            b1_wstrb    <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (st_valid) begin
                        st_ready <= 1'b0;
                        if (!is_store_type(store_type)) begin
                            state   <= S_DONE;
                            st_done <= 1'b1;
                        end else if (need_beat1 && (ALLOW_MISALIGNED == 0)) begin
                            state       <= S_DONE;
                            st_done     <= 1'b1;
                            st_misalign <= 1'b1;
                        end else begin
                            state      <= S_BEAT0;
                            mem_req    <= 1'b1;
                            mem_addr   <= {st_addr[31:2], 2'b00};
                            mem_wdata  <= data64[31:0];
                            mem_wstrb  <= strb8[3:0];
                            // Second-beat fields are captured now so inputs may change freely.
                            b1_pending <= need_beat1;
                            b1_addr    <= {st_addr[31:2], 2'b00} + 32'd4;
                            b1_wdata   <= data64[63:32];
                            b1_wstrb   <= strb8[7:4];
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ack) begin
                        if (b1_pending) begin
                            state     <= S_BEAT1;
                            mem_addr  <= b1_addr;
                            mem_wdata <= b1_wdata;
                            mem_wstrb <= b1_wstrb;
                        end else begin
                            state     <= S_DONE;
                            st_done   <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_addr  <= 32'd0;
                            mem_wdata <= 32'd0;
                            mem_wstrb <= 4'b0000;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ack) begin
                        state     <= S_DONE;
                        st_done   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'b0000;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    st_ready    <= 1'b1;
                    st_done     <= 1'b0;
                    st_misalign <= 1'b0;
                    b1_pending  <= 1'b0;
                end
            endcase
        end
    end

endmodule
